alu_64: RTL and testbench



---
 rtl/alu_64.sv | 104 ++++++++++
 tb/tb_alu_64.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_64.sv
// alu_64: execute-stage integer ALU with a registered result and NZVC flags.
// The datapath is purely combinational; one output register stage makes
// result and flags valid exactly one clock after the operands and opcode.
module alu_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  logic             is_add;
  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] carry_in_vec;
  logic [WIDTH-1:0] low_sum;
  logic             carry_into_msb;
  logic [1:0]       msb_sum;
  logic [WIDTH-1:0] sum;
  logic             sum_carry;
  logic             sum_overflow;

  logic [WIDTH-1:0] result_next;
  logic             negative_next;
  logic             zero_next;
  logic             overflow_next;
  logic             carry_out_next;

  // Decode the opcode into adder controls.
  always_comb begin
    is_add   = (cntrl == OP_ADD);
    is_sub   = (cntrl == OP_SUB);
    is_arith = is_add | is_sub;
  end

  // Shared adder: subtract is A + ~B + 1. The top bit is summed separately so
  // the carry into bit WIDTH-1 is available for the signed overflow flag.
  always_comb begin
    b_eff        = is_sub ? ~B : B;
    carry_in_vec = '0;
    carry_in_vec[0] = is_sub;
    low_sum = {1'b0, A[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + carry_in_vec;
    carry_into_msb = low_sum[WIDTH-1];
    msb_sum = {1'b0, A[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]} + {1'b0, carry_into_msb};
    sum          = {msb_sum[0], low_sum[WIDTH-2:0]};
    sum_carry    = msb_sum[1];
    sum_overflow = carry_into_msb ^ msb_sum[1];
  end

  // Select the operation result; undefined codes produce zero.
  always_comb begin
    result_next = '0;
    unique case (cntrl)
      OP_PASS_B: result_next = B;
      OP_ADD:    result_next = sum;
      OP_SUB:    result_next = sum;
      OP_AND:    result_next = A & B;
      OP_OR:     result_next = A | B;
      OP_XOR:    result_next = A ^ B;
      default:   result_next = '0;
    endcase
  end

  // Flags: N and Z follow the result for every code; V and C only for add/sub.
  always_comb begin
    negative_next  = result_next[WIDTH-1];
    zero_next      = (result_next == '0);
    overflow_next  = is_arith & sum_overflow;
    carry_out_next = is_arith & sum_carry;
  end

  // Output register; reset wins over any operation and leaves Z set.
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      result    <= result_next;
      negative  <= negative_next;
      zero      <= zero_next;
      overflow  <= overflow_next;
      carry_out <= carry_out_next;
    end
  end

endmodule

// File: tb/tb_alu_64.sv
// tb_alu_64: directed self-checking bench for alu_64.
module tb_alu_64;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  op;
  logic [63:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;

  int n_checks = 0;
  int n_fail   = 0;

  alu_64 dut (
    .clk       (clk),
    .reset     (reset),
    .A         (a),
    .B         (b),
    .cntrl     (op),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [63:0] r,
                           input logic n, input logic z, input logic v, input logic c);
    check_val({tag, ".result"}, result, r);
    check_val({tag, ".n"}, {63'd0, negative}, {63'd0, n});
    check_val({tag, ".z"}, {63'd0, zero}, {63'd0, z});
    check_val({tag, ".v"}, {63'd0, overflow}, {63'd0, v});
    check_val({tag, ".c"}, {63'd0, carry_out}, {63'd0, c});
  endtask

  // Drive inputs away from the edge, then let one rising edge capture them.
  task automatic step(input logic rst, input logic [63:0] av, input logic [63:0] bv,
                      input logic [2:0] opv);
    @(negedge clk);
    reset = rst;
    a     = av;
    b     = bv;
    op    = opv;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [63:0] av;
    logic [63:0] bv;
    logic [2:0]  opv;
    logic [63:0] r;
    logic        n, z, v, c;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [63:0] rb;

    reset = 1'b1;
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = 64'd1;
    op = 3'b010;

    // Reset held two cycles with inputs that would otherwise carry.
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    check_all("reset1", 64'd0, 0, 1, 0, 0);
    step(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    check_all("reset2", 64'd0, 0, 1, 0, 0);

    // Pass B with random operands, plus B = 0.
    for (int i = 0; i < 100; i++) begin
      rb = {$urandom, $urandom};
      step(1'b0, {$urandom, $urandom}, rb, 3'b000);
      check_val("passb.result", result, rb);
      check_val("passb.n", {63'd0, negative}, {63'd0, rb[63]});
      check_val("passb.z", {63'd0, zero}, {63'd0, (rb == 64'd0)});
      check_val("passb.vc", {62'd0, overflow, carry_out}, 64'd0);
    end
    step(1'b0, 64'h1234, 64'd0, 3'b000);
    check_all("passb_zero", 64'd0, 0, 1, 0, 0);

    vecs.push_back('{"add_1_1",     64'd1, 64'd1, 3'b010, 64'd2, 0, 0, 0, 0});
    vecs.push_back('{"add_ovf",     64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'h8000_0000_0000_0000, 1, 0, 1, 0});
    vecs.push_back('{"add_wrap",    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'd0, 0, 1, 0, 1});
    vecs.push_back('{"add_min_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b010, 64'd0, 0, 1, 1, 1});
    vecs.push_back('{"sub_5_5",     64'd5, 64'd5, 3'b011, 64'd0, 0, 1, 0, 1});
    vecs.push_back('{"sub_0_1",     64'd0, 64'd1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0});
    vecs.push_back('{"sub_ovf",     64'h8000_0000_0000_0000, 64'd1, 3'b011, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1});
    vecs.push_back('{"sub_3_5",     64'd3, 64'd5, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0});
    vecs.push_back('{"sub_9_4",     64'd9, 64'd4, 3'b011, 64'd5, 0, 0, 0, 1});
    vecs.push_back('{"and",         64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b100, 64'hF000_F000_F000_F000, 1, 0, 0, 0});
    vecs.push_back('{"or",          64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b101, 64'hFFF0_FFF0_FFF0_FFF0, 1, 0, 0, 0});
    vecs.push_back('{"xor",         64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b110, 64'h0FF0_0FF0_0FF0_0FF0, 0, 0, 0, 0});
    vecs.push_back('{"and_ones",    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0});
    vecs.push_back('{"xor_self",    64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 3'b110, 64'd0, 0, 1, 0, 0});
    vecs.push_back('{"undef_111",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111, 64'd0, 0, 1, 0, 0});
    vecs.push_back('{"undef_001",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b001, 64'd0, 0, 1, 0, 0});

    // Back-to-back vectors: operands change every cycle, and before each edge
    // the outputs must still show the previous vector.
    foreach (vecs[i]) begin
      @(negedge clk);
      reset = 1'b0;
      a     = vecs[i].av;
      b     = vecs[i].bv;
      op    = vecs[i].opv;
      #1;
      if (i > 0)
        check_val({vecs[i].tag, ".hold"}, result, vecs[i-1].r);
      @(posedge clk);
      #1;
      check_all(vecs[i].tag, vecs[i].r, vecs[i].n, vecs[i].z, vecs[i].v, vecs[i].c);
    end

    // Reset mid-sequence overrides an operation, then release resumes at once.
    step(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    check_all("pre_rst", 64'h8000_0000_0000_0000, 1, 0, 1, 0);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
    check_all("mid_rst", 64'd0, 0, 1, 0, 0);
    step(1'b0, 64'd10, 64'd20, 3'b010);
    check_all("post_rst", 64'd30, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
